// File: rtl/raster_cmd_scheduler_pkg.sv
// Shared types for the raster command path: command codes, queue entry layout
// and scheduler FSM encoding.
package raster_pkg;
  localparam int ARG_W = 12;
  localparam int ENTRY_W = 14;
  localparam logic [2:0] CLEAR_COORD = 3'd7;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_PIXEL = 2'b01,
    CMD_LINE  = 2'b10,
    CMD_RECT  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  // args = {x1, y1, p2, p3}, 3 bits each
  typedef struct packed {
    logic [1:0]       cmd;
    logic [ARG_W-1:0] args;
  } cmd_entry_t;
endpackage

// File: rtl/raster_cmd_scheduler_if.sv
// Source ports A/B plus rasterizer side of the command scheduler.
// master = sources/rasterizer, slave = scheduler.
interface raster_cmd_scheduler_if #(parameter int DEPTH = 4);
  import raster_pkg::*;
  logic                   a_valid, a_ready;
  logic [1:0]             a_cmd;
  logic [ARG_W-1:0]       a_args;
  logic                   b_valid, b_ready;
  logic [1:0]             b_cmd;
  logic [ARG_W-1:0]       b_args;
  logic [1:0]             rast_cmd;
  logic [ARG_W-1:0]       rast_args;
  logic                   rast_frame_sync;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   timeout_err;

  modport master (
    output a_valid, a_cmd, a_args, b_valid, b_cmd, b_args, rast_frame_sync,
    input  a_ready, b_ready, rast_cmd, rast_args, busy, fifo_count, timeout_err
  );
  modport slave (
    input  a_valid, a_cmd, a_args, b_valid, b_cmd, b_args, rast_frame_sync,
    output a_ready, b_ready, rast_cmd, rast_args, busy, fifo_count, timeout_err
  );
endinterface

// File: rtl/raster_cmd_scheduler_fifo.sv
// Command queue: DEPTH x W, combinational head read, async-reset pointers/count.
module cmd_fifo import raster_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  // DEPTH is a power of two, so pointers wrap on their own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/raster_cmd_scheduler.sv
// Round-robin arbiter of two command sources into a queue; issues one command
// at a time to the rasterizer and waits for frame_sync or a timeout.
module raster_cmd_scheduler import raster_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  raster_cmd_scheduler_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  prio_e            prio;
  state_e           state;
  logic [7:0]       tcnt;
  logic             full, empty, grant_a, grant_b, push, pop;
  logic [CW-1:0]    count, count_nxt;
  cmd_entry_t       head, wentry;
  logic [1:0]       rast_cmd_q;
  logic [ARG_W-1:0] rast_args_q;
  logic             busy_q, terr_q;

  // Ready ignores a same-cycle pop: a full queue refuses pushes that cycle
  assign bus.a_ready = !full && (prio == PRIO_A || !bus.b_valid);
  assign bus.b_ready = !full && (prio == PRIO_B || !bus.a_valid);
  assign grant_a     = bus.a_valid && bus.a_ready;
  assign grant_b     = bus.b_valid && bus.b_ready;

  assign wentry    = grant_a ? {bus.a_cmd, bus.a_args} : {bus.b_cmd, bus.b_args};
  assign push      = (grant_a || grant_b) && (wentry.cmd != CMD_NOP);
  assign pop       = (state == IDLE) && !empty;
  assign count_nxt = count + CW'(push) - CW'(pop);

  cmd_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // NOP grants still hand priority over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   prio <= PRIO_A;
    else if (grant_a || grant_b)  prio <= (prio == PRIO_A) ? PRIO_B : PRIO_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      rast_cmd_q  <= '0;
      rast_args_q <= '0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      terr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            rast_cmd_q  <= head.cmd;
            rast_args_q <= head.args;
            state       <= ISSUE;
            busy_q      <= 1'b1;
          end else begin
            busy_q <= (count_nxt != '0);
          end
        end
        ISSUE: begin
          rast_cmd_q <= '0;
          tcnt       <= '0;
          state      <= WAIT;
          busy_q     <= 1'b1;
        end
        WAIT: begin
          // busy mirrors the post-edge state, so it drops with the return to IDLE
          if (bus.rast_frame_sync) begin
            state  <= IDLE;
            busy_q <= (count_nxt != '0);
          end else if (tcnt == 8'(TIMEOUT - 1)) begin
            state  <= IDLE;
            terr_q <= 1'b1;
            busy_q <= (count_nxt != '0);
          end else begin
            tcnt   <= tcnt + 8'd1;
            busy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rast_cmd    = rast_cmd_q;
  assign bus.rast_args   = rast_args_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;
  assign bus.fifo_count  = count;
endmodule

// File: doc/raster_cmd_scheduler.md
# raster_cmd_scheduler

Sits between the command sources and the rasterizer. Accepts fully assembled draw commands from two requesters (host decoder port A, auxiliary source port B, e.g. refresh/auto-clear). Arbitrates round-robin into a small FIFO, then issues one command at a time to the rasterizer. Waits for the rasterizer's `frame_sync` (or a timeout) before issuing the next.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `TIMEOUT`, 64: max WAIT cycles before forced release; 2..255.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `a_valid` in 1: port A command valid.
- `a_ready` out 1: port A accept.
- `a_cmd` in 2: 00 NOP, 01 PIXEL/CLEAR, 10 LINE, 11 RECT.
- `a_args` in 12: {x1,y1,p2,p3}, 3 bits each; p2/p3 = x2/y2 (LINE) or width/height (RECT).
- `b_valid`, `b_ready`, `b_cmd`, `b_args`: as for port A, for port B.
- `rast_cmd` out 2: command to rasterizer; non-zero for exactly one cycle per issue.
- `rast_args` out 12: arguments; held stable from issue until next issue.
- `rast_frame_sync` in 1: rasterizer completion pulse.
- `busy` out 1: state != IDLE or FIFO non-empty.
- `fifo_count` out clog2(DEPTH)+1: occupancy.
- `timeout_err` out 1: one-cycle pulse when WAIT ends by timeout.

## Operation
- Handshake: transfer on the rising edge where `x_valid && x_ready`. Sources hold `cmd`/`args` stable while valid and not ready.
- `a_ready = !full && (prio==A || !b_valid)`; `b_ready = !full && (prio==B || !a_valid)`. At most one grant per cycle.
- `prio` resets to A and toggles to the other port after every grant. A single active requester gets back-to-back grants.
- Granted NOP (cmd 00): accepted, not enqueued, `prio` still toggles.
- `full` means `count == DEPTH`. A pop in the same cycle does not free a slot for that cycle.
- Simultaneous push and pop: count unchanged, both performed.
- FSM:
  - IDLE → ISSUE when count>0: pop head into output registers.
  - ISSUE (1 cycle): `rast_cmd` = entry cmd. → WAIT, timeout counter cleared.
  - WAIT: `rast_cmd`=0. → IDLE on `rast_frame_sync`=1. Otherwise counter increments; on reaching TIMEOUT → IDLE with `timeout_err` pulse.
- A `rast_frame_sync` outside WAIT is ignored.
- CLEAR is PIXEL with x1=y1=7. It is passed through unchanged, with no special scheduling.
- Reset mid-operation: FIFO flushed, all pending commands discarded, FSM → IDLE.

## Timing
- Reset values: `a_ready`/`b_ready` follow the combinational rule (1 when valid allows, since FIFO is empty). `rast_cmd`=0, `rast_args`=0, `busy`=0, `fifo_count`=0, `timeout_err`=0, `prio`=A.
- Latency, empty FIFO and idle FSM: handshake at edge T0 → IDLE sees count=1 → edge T1 enters ISSUE. `rast_cmd` is valid in the cycle after T1 and drops after T2.
- Minimum issue spacing: 3 cycles (ISSUE, WAIT with sync at its first edge, IDLE).
- Timeout: `timeout_err` is high in the cycle following the TIMEOUT-th WAIT cycle. The next issue may follow one cycle later.
- All outputs except `a_ready`/`b_ready` are registered.

## Structure
- Shared package `raster_pkg`:
  - command codes CMD_NOP/PIXEL/LINE/RECT;
  - CLEAR_COORD=7;
  - ARG_W=12;
  - ENTRY_W=14;
  - FSM state encoding IDLE/ISSUE/WAIT.
- Sub-module `cmd_fifo`: synchronous, DEPTH×ENTRY_W, push/pop/full/empty/count, async reset of pointers and count.
- Top level: arbiter, FSM, timeout counter, output registers.

## Test plan
- Single PIXEL on A (args x1=3,y1=5) with the FIFO empty → one-cycle `rast_cmd`=01 two edges after the handshake. `rast_args`=0x{3,5,0,0} held. `busy` clears one cycle after `rast_frame_sync`.
- A and B both valid continuously, rasterizer never returns sync, TIMEOUT=4 → grants alternate A,B,A,B. FIFO fills to 4 and both readies drop. Issues then occur in grant order with a `timeout_err` pulse each.
- FIFO full, pop and push requested in the same cycle → push refused that cycle, accepted next; `fifo_count` sequence 4,3,4.
- Only B valid for 3 cycles → 3 consecutive B grants. NOP from A is accepted but never issued; `fifo_count` unaffected.
- `rast_frame_sync` pulse during IDLE and during ISSUE → ignored. WAIT still requires its own sync or timeout.
- `rst_n` asserted during WAIT with 3 entries queued → all outputs return to reset values. No further `rast_cmd` after release.
